// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined ARM data-processing shifter.
// Holds operand-kind and shift-type codes, the stage-1 operation-class
// encoding, the stage-1 pipeline word and a small amount helper.
package shifter_pkg;

    localparam int DATA_W = 32;

    // Operand kinds presented on in_kind
    localparam logic [1:0] KIND_IMM_ROT   = 2'd0;
    localparam logic [1:0] KIND_SHIFT_IMM = 2'd1;
    localparam logic [1:0] KIND_SHIFT_REG = 2'd2;
    localparam logic [1:0] KIND_RSVD      = 2'd3;

    // Shift types presented on in_shift_type
    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    // What stage 2 does with the rotated word.
    //   PASS  : result = data,                 carry = cbit
    //   ROR   : result = rotated,              carry = rotated[31]
    //   SHR   : rotated, top amt bits := fill, carry = rotated[31]
    //   LSL   : rotated, low amt bits := 0,    carry = rotated[0]
    //   CONST : result = {32{fill}},           carry = cbit
    //   RRX   : {fill, rotated[30:0]},         carry = cbit
    typedef enum logic [2:0] {
        CLS_PASS  = 3'd0,
        CLS_ROR   = 3'd1,
        CLS_SHR   = 3'd2,
        CLS_LSL   = 3'd3,
        CLS_CONST = 3'd4,
        CLS_RRX   = 3'd5
    } op_class_e;

    // Decoded operation carried from stage 1 to stage 2
    typedef struct packed {
        op_class_e          cls;
        logic [4:0]         rot;   // rotate-right amount for the barrel
        logic [4:0]         amt;   // shift distance, used only for masking
        logic               fill;  // bit shifted in (ASR sign, RRX carry, const)
        logic               cbit;  // carry when it is not taken from the rotator
        logic [DATA_W-1:0]  data;  // operand to be rotated
    } s1_word_t;

    // A left shift by n equals a right rotate by (32 - n) mod 32
    function automatic logic [4:0] lsl_rot(input logic [4:0] n);
        return 5'd0 - n;
    endfunction

endpackage

// File: rtl/barrel_rotator.sv
// Combinational 32-bit rotate-right by a 5-bit amount, built as five
// mux levels (1, 2, 4, 8, 16).
// Ports:
//   data_in  : word to rotate
//   amount   : rotate-right distance 0..31
//   data_out : rotated word
module barrel_rotator
    import shifter_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic [4:0]        amount,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] lvl0_s;
    logic [DATA_W-1:0] lvl1_s;
    logic [DATA_W-1:0] lvl2_s;
    logic [DATA_W-1:0] lvl3_s;

    assign lvl0_s   = amount[0] ? {data_in[0],     data_in[31:1]}   : data_in;
    assign lvl1_s   = amount[1] ? {lvl0_s[1:0],    lvl0_s[31:2]}    : lvl0_s;
    assign lvl2_s   = amount[2] ? {lvl1_s[3:0],    lvl1_s[31:4]}    : lvl1_s;
    assign lvl3_s   = amount[3] ? {lvl2_s[7:0],    lvl2_s[31:8]}    : lvl2_s;
    assign data_out = amount[4] ? {lvl3_s[15:0],   lvl3_s[31:16]}   : lvl3_s;

endmodule

// File: rtl/shifter_unit.sv
// Two-stage pipelined ARM data-processing shifter (shifter_operand and
// shifter_carry_out). Stage 1 decodes the operand kind, shift type and
// amount into a rotate amount, an operation class and fill/carry bits,
// resolving every out-of-range case. Stage 2 rotates, masks and selects
// the carry. Valid/ready on both sides, one operation per cycle.
// Ports:
//   clk, reset_n              : clock, synchronous active-low reset
//   in_valid / in_ready       : request handshake
//   in_kind, in_shift_type    : operand form and shift type
//   in_amount                 : shifter_mux output (low bits used by kind)
//   in_imm8, in_rm, in_carry  : immediate_8, Rm, CPSR C
//   out_valid / out_ready     : result handshake
//   out_result, out_carry     : shifter_operand, shifter_carry_out
module shifter_unit
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [1:0]       in_shift_type,
    input  logic [WIDTH-1:0] in_amount,
    input  logic [7:0]       in_imm8,
    input  logic [WIDTH-1:0] in_rm,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry
);

    logic              s1_valid_r;
    s1_word_t          s1_r;
    s1_word_t          dec_s;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_result_r;
    logic              out_carry_r;
    logic              out_adv_s;
    logic [4:0]        imm_rot_s;
    logic [4:0]        n_s;
    logic [7:0]        s_amt_s;
    logic              s_ge32_s;
    logic              s_eq32_s;
    logic [DATA_W-1:0] rot_s;
    logic [DATA_W-1:0] shr_mask_s;
    logic [DATA_W-1:0] lsl_mask_s;
    logic [DATA_W-1:0] s2_result_s;
    logic              s2_carry_s;
    logic              unused_amount_s;

    // Output register may take a new word when empty or being drained
    assign out_adv_s = !out_valid_r || out_ready;
    assign in_ready  = !s1_valid_r || out_adv_s;

    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_carry  = out_carry_r;

    assign imm_rot_s = {in_amount[3:0], 1'b0};
    assign n_s       = in_amount[4:0];
    assign s_amt_s   = in_amount[7:0];
    assign s_ge32_s  = |s_amt_s[7:5];
    assign s_eq32_s  = (s_amt_s == 8'd32);

    assign unused_amount_s = ^in_amount[WIDTH-1:8];

    // Stage-1 decode: fold every form into (class, rotate, mask, fill, carry)
    always_comb begin
        dec_s.cls  = CLS_PASS;
        dec_s.rot  = 5'd0;
        dec_s.amt  = 5'd0;
        dec_s.fill = 1'b0;
        dec_s.cbit = in_carry;
        dec_s.data = in_rm;
        case (in_kind)
            KIND_IMM_ROT: begin
                dec_s.data = {24'd0, in_imm8};
                if (imm_rot_s == 5'd0) begin
                    dec_s.cls  = CLS_PASS;
                end else begin
                    dec_s.cls = CLS_ROR;
                    dec_s.rot = imm_rot_s;
                end
            end
            KIND_SHIFT_IMM: begin
                // n == 0 encodes LSL #0, LSR #32, ASR #32 and RRX
                case (in_shift_type)
                    SH_LSL: begin
                        if (n_s == 5'd0) begin
                            dec_s.cls = CLS_PASS;
                        end else begin
                            dec_s.cls = CLS_LSL;
                            dec_s.rot = lsl_rot(n_s);
                            dec_s.amt = n_s;
                        end
                    end
                    SH_LSR: begin
                        if (n_s == 5'd0) begin
                            dec_s.cls  = CLS_CONST;
                            dec_s.cbit = in_rm[31];
                        end else begin
                            dec_s.cls = CLS_SHR;
                            dec_s.rot = n_s;
                            dec_s.amt = n_s;
                        end
                    end
                    SH_ASR: begin
                        dec_s.fill = in_rm[31];
                        if (n_s == 5'd0) begin
                            dec_s.cls  = CLS_CONST;
                            dec_s.cbit = in_rm[31];
                        end else begin
                            dec_s.cls = CLS_SHR;
                            dec_s.rot = n_s;
                            dec_s.amt = n_s;
                        end
                    end
                    SH_ROR: begin
                        if (n_s == 5'd0) begin
                            dec_s.cls  = CLS_RRX;
                            dec_s.rot  = 5'd1;
                            dec_s.fill = in_carry;
                            dec_s.cbit = in_rm[0];
                        end else begin
                            dec_s.cls = CLS_ROR;
                            dec_s.rot = n_s;
                        end
                    end
                    default: dec_s.cls = CLS_PASS;
                endcase
            end
            KIND_SHIFT_REG: begin
                if (s_amt_s == 8'd0) begin
                    dec_s.cls = CLS_PASS;
                end else begin
                    case (in_shift_type)
                        SH_LSL: begin
                            if (!s_ge32_s) begin
                                dec_s.cls = CLS_LSL;
                                dec_s.rot = lsl_rot(s_amt_s[4:0]);
                                dec_s.amt = s_amt_s[4:0];
                            end else begin
                                dec_s.cls  = CLS_CONST;
                                dec_s.cbit = s_eq32_s ? in_rm[0] : 1'b0;
                            end
                        end
                        SH_LSR: begin
                            if (!s_ge32_s) begin
                                dec_s.cls = CLS_SHR;
                                dec_s.rot = s_amt_s[4:0];
                                dec_s.amt = s_amt_s[4:0];
                            end else begin
                                dec_s.cls  = CLS_CONST;
                                dec_s.cbit = s_eq32_s ? in_rm[31] : 1'b0;
                            end
                        end
                        SH_ASR: begin
                            dec_s.fill = in_rm[31];
                            if (!s_ge32_s) begin
                                dec_s.cls = CLS_SHR;
                                dec_s.rot = s_amt_s[4:0];
                                dec_s.amt = s_amt_s[4:0];
                            end else begin
                                dec_s.cls  = CLS_CONST;
                                dec_s.cbit = in_rm[31];
                            end
                        end
                        SH_ROR: begin
                            // Multiples of 32 leave rm intact but carry out bit 31
                            if (s_amt_s[4:0] == 5'd0) begin
                                dec_s.cls  = CLS_PASS;
                                dec_s.cbit = in_rm[31];
                            end else begin
                                dec_s.cls = CLS_ROR;
                                dec_s.rot = s_amt_s[4:0];
                            end
                        end
                        default: dec_s.cls = CLS_PASS;
                    endcase
                end
            end
            default: begin
                dec_s.cls  = CLS_PASS;
                dec_s.cbit = in_carry;
                dec_s.data = in_rm;
            end
        endcase
    end

    // Stage-1 register: loads whenever stage 1 is empty or draining forward
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_r       <= '0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_r <= dec_s;
            end
        end
    end

    barrel_rotator u_rot (
        .data_in  (s1_r.data),
        .amount   (s1_r.rot),
        .data_out (rot_s)
    );

    assign shr_mask_s = 32'hFFFF_FFFF >> s1_r.amt;
    assign lsl_mask_s = 32'hFFFF_FFFF << s1_r.amt;

    // Stage-2 result and carry selection from the rotated word
    always_comb begin
        s2_result_s = s1_r.data;
        s2_carry_s  = s1_r.cbit;
        case (s1_r.cls)
            CLS_PASS: begin
                s2_result_s = s1_r.data;
                s2_carry_s  = s1_r.cbit;
            end
            CLS_ROR: begin
                s2_result_s = rot_s;
                s2_carry_s  = rot_s[31];
            end
            CLS_SHR: begin
                s2_result_s = (rot_s & shr_mask_s) | ({32{s1_r.fill}} & ~shr_mask_s);
                s2_carry_s  = rot_s[31];
            end
            CLS_LSL: begin
                s2_result_s = rot_s & lsl_mask_s;
                s2_carry_s  = rot_s[0];
            end
            CLS_CONST: begin
                s2_result_s = {32{s1_r.fill}};
                s2_carry_s  = s1_r.cbit;
            end
            CLS_RRX: begin
                s2_result_s = {s1_r.fill, rot_s[30:0]};
                s2_carry_s  = s1_r.cbit;
            end
            default: begin
                s2_result_s = s1_r.data;
                s2_carry_s  = s1_r.cbit;
            end
        endcase
    end

    // Output register: holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_r  <= 1'b0;
            out_result_r <= 32'd0;
            out_carry_r  <= 1'b0;
        end else if (out_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_result_r <= s2_result_s;
                out_carry_r  <= s2_carry_s;
            end
        end
    end

endmodule

// File: tb/tb_shifter_unit.sv
// Scoreboard bench for shifter_unit: the driver pushes the hand-computed
// expected result for every accepted request, the monitor pops and compares
// on every output transfer.
module tb_shifter_unit;

    typedef struct {
        logic [1:0]  kind;
        logic [1:0]  st;
        logic [31:0] amt;
        logic [7:0]  imm;
        logic [31:0] rm;
        logic        cin;
        logic [31:0] res;
        logic        c;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        c;
        int          acc_edge;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = 2'd0;
    logic [1:0]  in_shift_type = 2'd0;
    logic [31:0] in_amount = 32'd0;
    logic [7:0]  in_imm8 = 8'd0;
    logic [31:0] in_rm = 32'd0;
    logic        in_carry = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_carry;

    vec_t  vecs[24];
    exp_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    tp_phase = 1'b0;
    bit    rdy_low = 1'b0;
    logic [31:0] rdy_pat = 32'hFFFF_FFFF;

    shifter_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_kind       (in_kind),
        .in_shift_type (in_shift_type),
        .in_amount     (in_amount),
        .in_imm8       (in_imm8),
        .in_rm         (in_rm),
        .in_carry      (in_carry),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_carry     (out_carry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer ready pattern, updated on the falling edge
    always @(negedge clk) begin
        out_ready = rdy_low ? 1'b0 : rdy_pat[0];
        rdy_pat   = {rdy_pat[0], rdy_pat[31:1]};
    end

    // Monitor: compares every output transfer against the scoreboard
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h carry %b, required no output", out_result, out_carry);
            end else begin
                e = sb_q.pop_front();
                if (out_result !== e.res || out_carry !== e.c) begin
                    errors++;
                    $display("FAIL result: got %h carry %b, required %h carry %b", out_result, out_carry, e.res, e.c);
                end
                if (tp_phase) begin
                    checks++;
                    if ((cyc + 1) - e.acc_edge != 2) begin
                        errors++;
                        $display("FAIL latency: got %0d edges, required 2", (cyc + 1) - e.acc_edge);
                    end
                end
            end
        end
    end

    task automatic setv(input int i, input logic [1:0] kind, input logic [1:0] st,
                        input logic [31:0] amt, input logic [7:0] imm, input logic [31:0] rm,
                        input logic cin, input logic [31:0] res, input logic c);
        vecs[i].kind = kind; vecs[i].st = st; vecs[i].amt = amt; vecs[i].imm = imm;
        vecs[i].rm = rm; vecs[i].cin = cin; vecs[i].res = res; vecs[i].c = c;
    endtask

    task automatic apply(input int i);
        in_kind       = vecs[i].kind;
        in_shift_type = vecs[i].st;
        in_amount     = vecs[i].amt;
        in_imm8       = vecs[i].imm;
        in_rm         = vecs[i].rm;
        in_carry      = vecs[i].cin;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic send(input int i, output int waited);
        int w;
        w = 0;
        @(negedge clk);
        #1;
        apply(i);
        in_valid = 1'b1;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        waited = w;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready %b, required 1 within 100 cycles", in_ready);
            in_valid = 1'b0;
        end else begin
            sb_q.push_back('{vecs[i].res, vecs[i].c, cyc + 1});
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int stalls;
        int idx;
        int acc;

        setv(0,  2'd0, 2'd0, 32'h0000_0004, 8'hFF, 32'h0,         1'b0, 32'hFF00_0000, 1'b1);
        setv(1,  2'd0, 2'd0, 32'h0000_0000, 8'hFF, 32'h0,         1'b1, 32'h0000_00FF, 1'b1);
        setv(2,  2'd1, 2'd1, 32'h0000_0000, 8'h00, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1);
        setv(3,  2'd1, 2'd2, 32'h0000_0000, 8'h00, 32'h8000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1);
        setv(4,  2'd1, 2'd3, 32'h0000_0000, 8'h00, 32'h8000_0001, 1'b1, 32'hC000_0000, 1'b1);
        setv(5,  2'd1, 2'd0, 32'h0000_0001, 8'h00, 32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1);
        setv(6,  2'd2, 2'd0, 32'h0000_0020, 8'h00, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        setv(7,  2'd2, 2'd0, 32'h0000_0021, 8'h00, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b0);
        setv(8,  2'd2, 2'd3, 32'h0000_0020, 8'h00, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1);
        setv(9,  2'd2, 2'd1, 32'h0000_0000, 8'h00, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0);
        setv(10, 2'd1, 2'd0, 32'h0000_0004, 8'h00, 32'h1234_5678, 1'b0, 32'h2345_6780, 1'b1);
        setv(11, 2'd1, 2'd1, 32'h0000_0008, 8'h00, 32'h1234_5678, 1'b1, 32'h0012_3456, 1'b0);
        setv(12, 2'd1, 2'd2, 32'h0000_0004, 8'h00, 32'h8000_00F0, 1'b1, 32'hF800_000F, 1'b0);
        setv(13, 2'd1, 2'd3, 32'h0000_0004, 8'h00, 32'h1234_5678, 1'b0, 32'h8123_4567, 1'b1);
        setv(14, 2'd2, 2'd2, 32'h0000_0028, 8'h00, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1);
        setv(15, 2'd2, 2'd1, 32'h0000_0020, 8'h00, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        setv(16, 2'd2, 2'd1, 32'h0000_00C8, 8'h00, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0);
        setv(17, 2'd2, 2'd3, 32'h0000_0024, 8'h00, 32'h1234_5678, 1'b0, 32'h8123_4567, 1'b1);
        setv(18, 2'd2, 2'd0, 32'h0000_001F, 8'h00, 32'h0000_0003, 1'b0, 32'h8000_0000, 1'b1);
        setv(19, 2'd3, 2'd1, 32'h0000_0005, 8'h00, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1);
        setv(20, 2'd0, 2'd0, 32'hFFFF_FFFF, 8'h3F, 32'h0,         1'b1, 32'h0000_00FC, 1'b0);
        setv(21, 2'd2, 2'd0, 32'hFFFF_FF01, 8'h00, 32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1);
        setv(22, 2'd2, 2'd2, 32'h0000_0008, 8'h00, 32'h7F00_0000, 1'b1, 32'h007F_0000, 1'b0);
        setv(23, 2'd2, 2'd1, 32'h0000_0100, 8'h00, 32'h0000_0005, 1'b1, 32'h0000_0005, 1'b1);

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_result", out_result, 32'd0);
        chk("reset_out_carry", {31'd0, out_carry}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        reset_n = 1'b1;

        // Throughput: 20 back-to-back operations, consumer always ready
        tp_phase = 1'b1;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            send(i, w);
            stalls += w;
        end
        idle();
        drain();
        tp_phase = 1'b0;
        chk("throughput_stalls", stalls, 32'd0);

        // Backpressure: consumer stalls 5 cycles while input streams
        rdy_low = 1'b1;
        idx = 20;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            apply(idx);
            in_valid = 1'b1;
            if (in_ready) begin
                sb_q.push_back('{vecs[idx].res, vecs[idx].c, cyc + 1});
                idx++;
                acc++;
            end
            @(posedge clk);
        end
        chk("backpressure_accepts", acc, 32'd2);
        rdy_low = 1'b0;
        for (int i = idx; i < 24; i++) send(i, w);
        for (int i = 0; i < 4; i++) send(i, w);
        idle();
        drain();

        // Irregular consumer readiness over the full vector set
        rdy_pat = 32'h6D3A_95C3;
        for (int i = 0; i < 24; i++) send(i, w);
        idle();
        drain();
        rdy_pat = 32'hFFFF_FFFF;

        // Reset with both stages full: nothing in flight may emerge
        rdy_low = 1'b1;
        send(0, w);
        send(1, w);
        idle();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_out_result", out_result, 32'd0);
        chk("midreset_out_carry", {31'd0, out_carry}, 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        reset_n = 1'b1;
        sb_q.delete();
        rdy_low = 1'b0;
        send(4, w);
        send(5, w);
        send(6, w);
        idle();
        drain();
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
